pacman_scan_gen: RTL and testbench

Raster scan generator driving `pacman_game` and the VGA pins. It counts physical VGA pixels and lines and produces `hsync`/`vsync`. It also maps the physical raster onto the 224x288 game field: game-space `sx`/`sy`, `game_pix_stb`, `frame_stb` and `display_enabled`, with integer upscaling and a centring offset. It sits between the pixel clock source and `pacman_game`; the game's RGB output is gated by this block's `vga_active`.

---
 rtl/pacman_scan_gen_pkg.sv | 41 ++++
 rtl/pacman_scan_gen_scaler.sv | 69 ++++++
 rtl/pacman_scan_gen.sv | 196 +++++++++++++++++++
 tb/tb_pacman_scan_gen.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pacman_scan_gen_pkg.sv
// ============================================================================
// Module      : pacman_scan_gen_pkg
// Description : Shared VGA timing defaults (VGA_*) and Pac-Man field
//               geometry (PACMAN_*) for the raster scan generator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pacman_scan_gen_pkg;

  // VGA 640x480@60 timing group
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  // Pac-Man game field group
  localparam int PACMAN_H_VISIBLE_AREA = 224;
  localparam int PACMAN_V_VISIBLE_AREA = 288;
  localparam int PACMAN_SCALE          = 1;
  localparam int PACMAN_H_OFFSET       = 208;
  localparam int PACMAN_V_OFFSET       = 96;

  typedef struct packed {
    logic in_win;
    logic sub_zero;
  } axis_flags_t;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pacman_scan_gen_scaler.sv
// ============================================================================
// Module      : scan_axis_scaler
// Description : One raster axis mapped onto game space: window detect,
//               SCALE sub-counter and game coordinate. Outputs are the
//               next-cycle values so the parent can register them in step.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module scan_axis_scaler
  import pacman_scan_gen_pkg::*;
#(
  parameter int POS_W   = 10,
  parameter int COORD_W = 8,
  parameter int START   = 0,
  parameter int LEN     = 1,
  parameter int SCALE   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [POS_W-1:0]   pos_d,
  input  logic               adv,
  output axis_flags_t        flags_d,
  output logic [COORD_W-1:0] coord_d
);

  localparam int               SUB_W      = cnt_width(SCALE);
  localparam logic [POS_W-1:0] C_START    = POS_W'(START);
  localparam logic [POS_W-1:0] C_END      = POS_W'(START + LEN * SCALE);
  localparam logic [SUB_W-1:0] C_SUB_LAST = SUB_W'(SCALE - 1);

  logic [SUB_W-1:0]   sub_q;
  logic [SUB_W-1:0]   sub_d;
  logic [COORD_W-1:0] coord_q;
  logic               in_win;

  always_comb begin
    in_win  = (pos_d >= C_START) && (pos_d < C_END);
    sub_d   = sub_q;
    coord_d = coord_q;
    // The left/top edge re-seeds the counters, so no state leaks across lines
    if (!in_win || (pos_d == C_START)) begin
      sub_d   = '0;
      coord_d = '0;
    end else if (adv) begin
      if (sub_q == C_SUB_LAST) begin
        sub_d   = '0;
        coord_d = coord_q + COORD_W'(1);
      end else begin
        sub_d = sub_q + SUB_W'(1);
      end
    end
    flags_d.in_win   = in_win;
    flags_d.sub_zero = (sub_d == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sub_q   <= '0;
      coord_q <= '0;
    end else begin
      sub_q   <= sub_d;
      coord_q <= coord_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pacman_scan_gen.sv
// ============================================================================
// Module      : pacman_scan_gen
// Description : VGA raster scan generator with game-field mapping (sx/sy,
//               game_pix_stb, frame_stb). Build option SCAN_SYNC_DELAY_EN
//               delays hsync/vsync/vga_active by one pixel clock.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pacman_scan_gen
  import pacman_scan_gen_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter int GAME_W   = PACMAN_H_VISIBLE_AREA,
  parameter int GAME_H   = PACMAN_V_VISIBLE_AREA,
  parameter int SCALE    = PACMAN_SCALE,
  parameter int H_OFFSET = PACMAN_H_OFFSET,
  parameter int V_OFFSET = PACMAN_V_OFFSET
) (
  input  logic                       vga_pix_clk,
  input  logic                       rst,
  output logic                       hsync,
  output logic                       vsync,
  output logic                       vga_active,
  output logic                       display_enabled,
  output logic [$clog2(GAME_W)-1:0]  sx,
  output logic [$clog2(GAME_H)-1:0]  sy,
  output logic                       game_pix_stb,
  output logic                       frame_stb
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_W     = $clog2(H_TOTAL);
  localparam int V_W     = $clog2(V_TOTAL);
  localparam int SX_W    = $clog2(GAME_W);
  localparam int SY_W    = $clog2(GAME_H);

  localparam logic [H_W-1:0] C_H_LAST     = H_W'(H_TOTAL - 1);
  localparam logic [V_W-1:0] C_V_LAST     = V_W'(V_TOTAL - 1);
  localparam logic [H_W-1:0] C_H_ACTIVE   = H_W'(H_ACTIVE);
  localparam logic [V_W-1:0] C_V_ACTIVE   = V_W'(V_ACTIVE);
  localparam logic [H_W-1:0] C_HS_START   = H_W'(H_ACTIVE + H_FP);
  localparam logic [H_W-1:0] C_HS_END     = H_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [V_W-1:0] C_VS_START   = V_W'(V_ACTIVE + V_FP);
  localparam logic [V_W-1:0] C_VS_END     = V_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic           C_REPEAT_STB = (SCALE > 1);

  logic            run_q;
  logic [H_W-1:0]  h_q, h_d;
  logic [V_W-1:0]  v_q, v_d;

  logic            hsync_q, hsync_d;
  logic            vsync_q, vsync_d;
  logic            vga_active_q, vga_active_d;
  logic            display_enabled_q, display_enabled_d;
  logic [SX_W-1:0] sx_q, sx_d;
  logic [SY_W-1:0] sy_q, sy_d;
  logic            game_pix_stb_q, game_pix_stb_d;
  logic            frame_stb_q, frame_stb_d;

  axis_flags_t     h_flags, v_flags;
  logic [SX_W-1:0] h_coord;
  logic [SY_W-1:0] v_coord;
  logic            line_wrap;

  // Position presented on the coming edge; the first running edge shows (0,0)
  always_comb begin
    h_d = '0;
    v_d = '0;
    if (run_q) begin
      if (h_q == C_H_LAST) begin
        h_d = '0;
        v_d = (v_q == C_V_LAST) ? '0 : v_q + V_W'(1);
      end else begin
        h_d = h_q + H_W'(1);
        v_d = v_q;
      end
    end
    line_wrap = (h_d == '0);
  end

  scan_axis_scaler #(
    .POS_W   (H_W),
    .COORD_W (SX_W),
    .START   (H_OFFSET),
    .LEN     (GAME_W),
    .SCALE   (SCALE)
  ) u_h_scaler (
    .clk     (vga_pix_clk),
    .rst     (rst),
    .pos_d   (h_d),
    .adv     (1'b1),
    .flags_d (h_flags),
    .coord_d (h_coord)
  );

  scan_axis_scaler #(
    .POS_W   (V_W),
    .COORD_W (SY_W),
    .START   (V_OFFSET),
    .LEN     (GAME_H),
    .SCALE   (SCALE)
  ) u_v_scaler (
    .clk     (vga_pix_clk),
    .rst     (rst),
    .pos_d   (v_d),
    .adv     (line_wrap),
    .flags_d (v_flags),
    .coord_d (v_coord)
  );

  always_comb begin
    hsync_d           = !((h_d >= C_HS_START) && (h_d < C_HS_END));
    vsync_d           = !((v_d >= C_VS_START) && (v_d < C_VS_END));
    vga_active_d      = (h_d < C_H_ACTIVE) && (v_d < C_V_ACTIVE);
    display_enabled_d = h_flags.in_win && v_flags.in_win;
    sx_d              = display_enabled_d ? h_coord : '0;
    sy_d              = display_enabled_d ? v_coord : '0;
    // With SCALE>1 every physical line of a game row strobes, not just its first
    game_pix_stb_d    = display_enabled_d && h_flags.sub_zero &&
                        (C_REPEAT_STB || v_flags.sub_zero);
    frame_stb_d       = (h_d == '0) && (v_d == '0);
  end

  always_ff @(posedge vga_pix_clk) begin
    if (!rst) begin
      run_q             <= 1'b0;
      h_q               <= '0;
      v_q               <= '0;
      hsync_q           <= 1'b1;
      vsync_q           <= 1'b1;
      vga_active_q      <= 1'b0;
      display_enabled_q <= 1'b0;
      sx_q              <= '0;
      sy_q              <= '0;
      game_pix_stb_q    <= 1'b0;
      frame_stb_q       <= 1'b0;
    end else begin
      run_q             <= 1'b1;
      h_q               <= h_d;
      v_q               <= v_d;
      hsync_q           <= hsync_d;
      vsync_q           <= vsync_d;
      vga_active_q      <= vga_active_d;
      display_enabled_q <= display_enabled_d;
      sx_q              <= sx_d;
      sy_q              <= sy_d;
      game_pix_stb_q    <= game_pix_stb_d;
      frame_stb_q       <= frame_stb_d;
    end
  end

`ifdef SCAN_SYNC_DELAY_EN
  logic hsync_dly_q;
  logic vsync_dly_q;
  logic vga_active_dly_q;

  // Aligns sync/blanking with a downstream pixel path that has one map-read stage
  always_ff @(posedge vga_pix_clk) begin
    if (!rst) begin
      hsync_dly_q      <= 1'b1;
      vsync_dly_q      <= 1'b1;
      vga_active_dly_q <= 1'b0;
    end else begin
      hsync_dly_q      <= hsync_q;
      vsync_dly_q      <= vsync_q;
      vga_active_dly_q <= vga_active_q;
    end
  end

  assign hsync      = hsync_dly_q;
  assign vsync      = vsync_dly_q;
  assign vga_active = vga_active_dly_q;
`else
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign vga_active = vga_active_q;
`endif

  assign display_enabled = display_enabled_q;
  assign sx              = sx_q;
  assign sy              = sy_q;
  assign game_pix_stb    = game_pix_stb_q;
  assign frame_stb       = frame_stb_q;

endmodule

`default_nettype wire

// File: tb/tb_pacman_scan_gen.sv
// ============================================================================
// Module      : tb_pacman_scan_gen
// Description : Self-checking bench for pacman_scan_gen: two shrunken timing
//               configurations (SCALE=2 and SCALE=1) plus the default one,
//               checked each cycle against an arithmetic position model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pacman_scan_gen;

`ifdef SCAN_SYNC_DELAY_EN
  localparam int DLY = 1;
`else
  localparam int DLY = 0;
`endif

  typedef struct packed {
    int hs; int vs; int act; int de; int sx; int sy; int stb; int fr;
  } outs_t;

  typedef struct {
    int ha; int hfp; int hsy; int hbp; int va; int vfp; int vsy; int vbp;
    int gw; int gh; int sc; int ho; int vo;
  } cfg_t;

  typedef struct {
    int    k;
    outs_t e;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic a_hs, a_vs, a_act, a_de, a_stb, a_fr;
  logic [1:0] a_sx;
  logic [1:0] a_sy;
  logic b_hs, b_vs, b_act, b_de, b_stb, b_fr;
  logic [2:0] b_sx;
  logic [1:0] b_sy;
  logic c_hs, c_vs, c_act, c_de, c_stb, c_fr;
  logic [7:0] c_sx;
  logic [8:0] c_sy;

  pacman_scan_gen #(
    .H_ACTIVE(20), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(12), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .GAME_W(4), .GAME_H(3), .SCALE(2), .H_OFFSET(2), .V_OFFSET(3)
  ) dut_a (
    .vga_pix_clk(clk), .rst(rst), .hsync(a_hs), .vsync(a_vs),
    .vga_active(a_act), .display_enabled(a_de), .sx(a_sx), .sy(a_sy),
    .game_pix_stb(a_stb), .frame_stb(a_fr)
  );

  pacman_scan_gen #(
    .H_ACTIVE(20), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(12), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .GAME_W(5), .GAME_H(4), .SCALE(1), .H_OFFSET(7), .V_OFFSET(2)
  ) dut_b (
    .vga_pix_clk(clk), .rst(rst), .hsync(b_hs), .vsync(b_vs),
    .vga_active(b_act), .display_enabled(b_de), .sx(b_sx), .sy(b_sy),
    .game_pix_stb(b_stb), .frame_stb(b_fr)
  );

  pacman_scan_gen dut_c (
    .vga_pix_clk(clk), .rst(rst), .hsync(c_hs), .vsync(c_vs),
    .vga_active(c_act), .display_enabled(c_de), .sx(c_sx), .sy(c_sy),
    .game_pix_stb(c_stb), .frame_stb(c_fr)
  );

  int    errors = 0;
  int    checks = 0;
  cfg_t  cfgs[3];
  int    pos[3];
  bit    run[3];
  outs_t und_prev[3];
  outs_t exp_o[3];
  outs_t cap[0:499];
  int    ksince = -1;
  bit    cap_en = 1'b0;

  function automatic outs_t reset_outs();
    outs_t o;
    o = '0;
    o.hs = 1;
    o.vs = 1;
    return o;
  endfunction

  // Expected outputs for a physical position, straight from the raster rules
  function automatic outs_t model_pos(input cfg_t c, input int h, input int v);
    outs_t o;
    int hr, vr;
    bit in_h, in_v;
    o.hs  = (h >= c.ha + c.hfp && h < c.ha + c.hfp + c.hsy) ? 0 : 1;
    o.vs  = (v >= c.va + c.vfp && v < c.va + c.vfp + c.vsy) ? 0 : 1;
    o.act = (h < c.ha && v < c.va) ? 1 : 0;
    in_h  = (h >= c.ho && h < c.ho + c.gw * c.sc);
    in_v  = (v >= c.vo && v < c.vo + c.gh * c.sc);
    o.de  = (in_h && in_v) ? 1 : 0;
    hr    = h - c.ho;
    vr    = v - c.vo;
    o.sx  = o.de ? hr / c.sc : 0;
    o.sy  = o.de ? vr / c.sc : 0;
    o.stb = (o.de == 1 && hr % c.sc == 0 && (c.sc > 1 || vr % c.sc == 0)) ? 1 : 0;
    o.fr  = (h == 0 && v == 0) ? 1 : 0;
    return o;
  endfunction

  function automatic outs_t mk(input logic hs, input logic vs, input logic act,
                               input logic de, input int sx, input int sy,
                               input logic stb, input logic fr);
    outs_t o;
    o.hs = int'(hs); o.vs = int'(vs); o.act = int'(act); o.de = int'(de);
    o.sx = sx; o.sy = sy; o.stb = int'(stb); o.fr = int'(fr);
    return o;
  endfunction

  function automatic outs_t get_act(input int i);
    case (i)
      0:       return mk(a_hs, a_vs, a_act, a_de, int'(a_sx), int'(a_sy), a_stb, a_fr);
      1:       return mk(b_hs, b_vs, b_act, b_de, int'(b_sx), int'(b_sy), b_stb, b_fr);
      default: return mk(c_hs, c_vs, c_act, c_de, int'(c_sx), int'(c_sy), c_stb, c_fr);
    endcase
  endfunction

  function automatic string fmt(input outs_t o);
    return $sformatf("hs=%0d vs=%0d act=%0d de=%0d sx=%0d sy=%0d stb=%0d fr=%0d",
                     o.hs, o.vs, o.act, o.de, o.sx, o.sy, o.stb, o.fr);
  endfunction

  task automatic check_o(input string name, input outs_t act, input outs_t exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got {%s} want {%s}", name, fmt(act), fmt(exp));
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // One pixel clock: advance the model with the DUTs, then compare mid-cycle
  task automatic step();
    outs_t und, dly, e;
    int ht, tot;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      ht  = cfgs[i].ha + cfgs[i].hfp + cfgs[i].hsy + cfgs[i].hbp;
      tot = ht * (cfgs[i].va + cfgs[i].vfp + cfgs[i].vsy + cfgs[i].vbp);
      if (!rst) begin
        run[i] = 1'b0;
        und    = reset_outs();
        dly    = reset_outs();
      end else begin
        pos[i] = run[i] ? (pos[i] + 1) % tot : 0;
        run[i] = 1'b1;
        und    = model_pos(cfgs[i], pos[i] % ht, pos[i] / ht);
        dly    = und_prev[i];
      end
      e = und;
      if (DLY == 1) begin
        e.hs  = dly.hs;
        e.vs  = dly.vs;
        e.act = dly.act;
      end
      exp_o[i]    = e;
      und_prev[i] = und;
    end
    ksince = rst ? ksince + 1 : -1;
    @(negedge clk);
    for (int i = 0; i < 3; i++)
      check_o($sformatf("model dut%0d pos%0d", i, pos[i]), get_act(i), exp_o[i]);
    if (cap_en && ksince >= 0 && ksince < 500) cap[ksince] = get_act(0);
  endtask

  vec_t  vecs[$];
  outs_t tact;
  int    n, first_low, low_cnt, act_cnt, rlen;
  bit    found;

  function automatic vec_t v(input int k, input int hs, input int vs, input int act,
                             input int de, input int sx, input int sy, input int stb,
                             input int fr);
    vec_t r;
    r.k = k;
    r.e.hs = hs; r.e.vs = vs; r.e.act = act; r.e.de = de;
    r.e.sx = sx; r.e.sy = sy; r.e.stb = stb; r.e.fr = fr;
    return r;
  endfunction

  initial begin
    cfgs[0] = '{ha:20, hfp:2, hsy:3, hbp:3, va:12, vfp:1, vsy:2, vbp:2,
                gw:4, gh:3, sc:2, ho:2, vo:3};
    cfgs[1] = '{ha:20, hfp:2, hsy:3, hbp:3, va:12, vfp:1, vsy:2, vbp:2,
                gw:5, gh:4, sc:1, ho:7, vo:2};
    cfgs[2] = '{ha:640, hfp:16, hsy:96, hbp:48, va:480, vfp:10, vsy:2, vbp:33,
                gw:224, gh:288, sc:1, ho:208, vo:96};
    for (int i = 0; i < 3; i++) begin
      pos[i] = 0;
      run[i] = 1'b0;
      und_prev[i] = reset_outs();
    end

    // SCALE=2 vectors, k = cycles since reset release (h = k%28, v = k/28)
    vecs.push_back(v(  0, 1,1,1, 0,0,0,0,1));
    vecs.push_back(v(  1, 1,1,1, 0,0,0,0,0));
    vecs.push_back(v( 19, 1,1,1, 0,0,0,0,0));
    vecs.push_back(v( 20, 1,1,0, 0,0,0,0,0));
    vecs.push_back(v( 22, 0,1,0, 0,0,0,0,0));
    vecs.push_back(v( 24, 0,1,0, 0,0,0,0,0));
    vecs.push_back(v( 25, 1,1,0, 0,0,0,0,0));
    vecs.push_back(v( 86, 1,1,1, 1,0,0,1,0));
    vecs.push_back(v( 87, 1,1,1, 1,0,0,0,0));
    vecs.push_back(v( 88, 1,1,1, 1,1,0,1,0));
    vecs.push_back(v( 93, 1,1,1, 1,3,0,0,0));
    vecs.push_back(v( 94, 1,1,1, 0,0,0,0,0));
    vecs.push_back(v(114, 1,1,1, 1,0,0,1,0));
    vecs.push_back(v(116, 1,1,1, 1,1,0,1,0));
    vecs.push_back(v(142, 1,1,1, 1,0,1,1,0));
    vecs.push_back(v(229, 1,1,1, 1,1,2,0,0));
    vecs.push_back(v(254, 1,1,1, 0,0,0,0,0));
    vecs.push_back(v(364, 1,0,0, 0,0,0,0,0));
    vecs.push_back(v(419, 1,0,0, 0,0,0,0,0));
    vecs.push_back(v(420, 1,1,0, 0,0,0,0,0));
    vecs.push_back(v(475, 1,1,0, 0,0,0,0,0));
    vecs.push_back(v(476, 1,1,1, 0,0,0,0,1));

    // Held in reset: every output at its reset value
    rst = 1'b0;
    repeat (3) step();
    check_o("reset_a", get_act(0), reset_outs());
    check_o("reset_c", get_act(2), reset_outs());

    // One uninterrupted frame of the SCALE=2 instance, then the vector table
    cap_en = 1'b1;
    rst = 1'b1;
    repeat (480) step();
    cap_en = 1'b0;
    foreach (vecs[j]) begin
      tact     = cap[vecs[j].k];
      tact.hs  = cap[vecs[j].k + DLY].hs;
      tact.vs  = cap[vecs[j].k + DLY].vs;
      tact.act = cap[vecs[j].k + DLY].act;
      check_o($sformatf("vec k=%0d", vecs[j].k), tact, vecs[j].e);
    end

    // Frame strobe on release, and the period to the next one
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
    check_int("release_frame_stb", int'(a_fr), 1);
    n = -1;
    found = 1'b0;
    for (int j = 1; j <= 1000 && !found; j++) begin
      step();
      if (a_fr) begin
        found = 1'b1;
        n = j;
      end
    end
    check_int("frame_period", n, 476);

    // Reset mid-line at (h=15, v=6), then release
    for (int j = 0; j < 600 && pos[0] != 6 * 28 + 15; j++) step();
    check_int("reach_midline", pos[0], 6 * 28 + 15);
    rst = 1'b0;
    step();
    check_o("midreset_a", get_act(0), reset_outs());
    check_o("midreset_b", get_act(1), reset_outs());
    rst = 1'b1;
    step();
    check_int("rel_frame_stb", int'(a_fr), 1);
    check_int("rel_sx", int'(a_sx), 0);
    check_int("rel_de", int'(a_de), 0);

    // First line of the default timing (current sample is k=0)
    first_low = -1;
    low_cnt = 0;
    act_cnt = 0;
    for (int k = 0; k <= 800; k++) begin
      if (k > 0) step();
      if (k >= DLY && k < 800 + DLY) begin
        if (!c_hs) begin
          low_cnt++;
          if (first_low < 0) first_low = k;
        end
        if (c_act) act_cnt++;
      end
    end
    check_int("hsync_first_low", first_low, 656 + DLY);
    check_int("hsync_low_cycles", low_cnt, 96);
    check_int("active_cycles", act_cnt, 640);

    // Random reset pulses over several small frames
    for (int j = 0; j < 6000; j++) begin
      if ($urandom_range(0, 999) == 0) begin
        rlen = $urandom_range(1, 3);
        rst = 1'b0;
        repeat (rlen) step();
        rst = 1'b1;
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
